// File: rtl/eu_speriph_plug_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eu_speriph_plug_arbiter_pkg
// Description : Shared constants, types and helpers for the event-unit plug arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package eu_speriph_plug_arbiter_pkg;

    localparam int NB_CORES            = 4;
    localparam int NB_SPERIPH_PLUGS_EU = 2;
    localparam int EU_ID_WIDTH         = NB_CORES + 1;

    // Plug index type for the default cluster configuration.
    typedef logic [$clog2(NB_SPERIPH_PLUGS_EU)-1:0] plug_idx_t;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eu_arb_owner_fifo.sv
`default_nettype none
// ============================================================================
// Module      : eu_arb_owner_fifo
// Description : Small in-order FIFO recording which plug owns each outstanding
//               transaction; head is the owner of the next response.
// Revision    : 1.0 - initial release
// ============================================================================
module eu_arb_owner_fifo
    import eu_speriph_plug_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int c_PTR_W = idx_width(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            // A simultaneous push and pop leaves occupancy unchanged.
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/eu_speriph_plug_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eu_speriph_plug_arbiter
// Description : Round-robin arbiter sharing the event-unit slave port among the
//               speriph plugs, routing each response back to its issuing plug.
// Revision    : 1.0 - initial release
// ============================================================================
module eu_speriph_plug_arbiter
    import eu_speriph_plug_arbiter_pkg::*;
#(
    parameter int NB_PLUGS  = NB_SPERIPH_PLUGS_EU,
    parameter int ID_WIDTH  = EU_ID_WIDTH,
    parameter int MAX_OUTST = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NB_PLUGS-1:0]                slv_req_i,
    input  logic [NB_PLUGS-1:0][31:0]          slv_add_i,
    input  logic [NB_PLUGS-1:0]                slv_wen_i,
    input  logic [NB_PLUGS-1:0][31:0]          slv_wdata_i,
    input  logic [NB_PLUGS-1:0][3:0]           slv_be_i,
    input  logic [NB_PLUGS-1:0][ID_WIDTH-1:0]  slv_id_i,
    output logic [NB_PLUGS-1:0]                slv_gnt_o,
    output logic [NB_PLUGS-1:0]                slv_r_valid_o,
    output logic [31:0]                        slv_r_rdata_o,
    output logic                               slv_r_opc_o,
    output logic [ID_WIDTH-1:0]                slv_r_id_o,
    output logic                               mst_req_o,
    output logic [31:0]                        mst_add_o,
    output logic                               mst_wen_o,
    output logic [31:0]                        mst_wdata_o,
    output logic [3:0]                         mst_be_o,
    output logic [ID_WIDTH-1:0]                mst_id_o,
    input  logic                               mst_gnt_i,
    input  logic                               mst_r_valid_i,
    input  logic [31:0]                        mst_r_rdata_i,
    input  logic                               mst_r_opc_i,
    input  logic [ID_WIDTH-1:0]                mst_r_id_i,
    output logic                               err_o
);

    localparam int c_IDX_W = idx_width(NB_PLUGS);
    localparam logic [c_IDX_W-1:0] c_LAST_PLUG = c_IDX_W'(NB_PLUGS - 1);

    logic [c_IDX_W-1:0] r_ptr;
    logic               r_lock;
    logic [c_IDX_W-1:0] r_lock_sel;
    logic               r_err;

    logic [c_IDX_W-1:0] w_scan_sel;
    logic [c_IDX_W:0]   w_cand;
    logic               w_found;
    logic [c_IDX_W-1:0] w_sel;
    logic               w_any_req;
    logic               w_full;
    logic               w_empty;
    logic               w_hs;
    logic               w_pop;
    logic [c_IDX_W-1:0] w_head;

    // Circular scan for the first requester at or after the pointer.
    always_comb begin
        w_scan_sel = r_ptr;
        w_found    = 1'b0;
        w_cand     = '0;
        for (int i = 0; i < NB_PLUGS; i++) begin
            w_cand = {1'b0, r_ptr} + (c_IDX_W+1)'(i);
            if (w_cand >= (c_IDX_W+1)'(NB_PLUGS)) begin
                w_cand = w_cand - (c_IDX_W+1)'(NB_PLUGS);
            end
            if (!w_found && slv_req_i[w_cand[c_IDX_W-1:0]]) begin
                w_scan_sel = w_cand[c_IDX_W-1:0];
                w_found    = 1'b1;
            end
        end
    end

    assign w_sel     = r_lock ? r_lock_sel : w_scan_sel;
    assign w_any_req = |slv_req_i;
    assign mst_req_o = w_any_req & ~w_full;
    assign w_hs      = mst_req_o & mst_gnt_i;
    assign w_pop     = mst_r_valid_i & ~w_empty;

    // Payload is forced to zero while idle so the port is quiet after reset.
    assign mst_add_o   = w_any_req ? slv_add_i[w_sel]   : '0;
    assign mst_wen_o   = w_any_req ? slv_wen_i[w_sel]   : 1'b0;
    assign mst_wdata_o = w_any_req ? slv_wdata_i[w_sel] : '0;
    assign mst_be_o    = w_any_req ? slv_be_i[w_sel]    : '0;
    assign mst_id_o    = w_any_req ? slv_id_i[w_sel]    : '0;

    always_comb begin
        slv_gnt_o     = '0;
        slv_r_valid_o = '0;
        if (w_hs) begin
            slv_gnt_o[w_sel] = 1'b1;
        end
        if (w_pop) begin
            slv_r_valid_o[w_head] = 1'b1;
        end
    end

    assign slv_r_rdata_o = mst_r_rdata_i;
    assign slv_r_opc_o   = mst_r_opc_i;
    assign slv_r_id_o    = mst_r_id_i;
    assign err_o         = r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr      <= '0;
            r_lock     <= 1'b0;
            r_lock_sel <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_hs) begin
                r_ptr  <= (w_sel == c_LAST_PLUG) ? '0 : w_sel + c_IDX_W'(1);
                r_lock <= 1'b0;
            end else if (mst_req_o) begin
                r_lock     <= 1'b1;
                r_lock_sel <= w_sel;
            end
            if (mst_r_valid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    eu_arb_owner_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (c_IDX_W)
    ) u_owner_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_hs),
        .i_pop   (w_pop),
        .i_data  (w_sel),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // A locked plug must keep requesting until it is granted.
    a_lock_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        r_lock |-> slv_req_i[r_lock_sel]);

endmodule
`default_nettype wire

// File: tb/tb_eu_speriph_plug_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_eu_speriph_plug_arbiter
// Description : Directed scoreboard bench for the event-unit plug arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eu_speriph_plug_arbiter;

    localparam int NP = 2;
    localparam int IW = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NP-1:0]        slv_req;
    logic [NP-1:0][31:0]  slv_add;
    logic [NP-1:0]        slv_wen;
    logic [NP-1:0][31:0]  slv_wdata;
    logic [NP-1:0][3:0]   slv_be;
    logic [NP-1:0][IW-1:0] slv_id;
    logic [NP-1:0]        slv_gnt;
    logic [NP-1:0]        slv_r_valid;
    logic [31:0]          slv_r_rdata;
    logic                 slv_r_opc;
    logic [IW-1:0]        slv_r_id;
    logic                 mst_req;
    logic [31:0]          mst_add;
    logic                 mst_wen;
    logic [31:0]          mst_wdata;
    logic [3:0]           mst_be;
    logic [IW-1:0]        mst_id;
    logic                 mst_gnt;
    logic                 mst_r_valid;
    logic [31:0]          mst_r_rdata;
    logic                 mst_r_opc;
    logic [IW-1:0]        mst_r_id;
    logic                 err;

    localparam logic [31:0] ADD0 = 32'h1000_0000;
    localparam logic [31:0] ADD1 = 32'h2000_0004;

    always #5 clk = ~clk;

    eu_speriph_plug_arbiter #(
        .NB_PLUGS  (NP),
        .ID_WIDTH  (IW),
        .MAX_OUTST (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .slv_req_i     (slv_req),
        .slv_add_i     (slv_add),
        .slv_wen_i     (slv_wen),
        .slv_wdata_i   (slv_wdata),
        .slv_be_i      (slv_be),
        .slv_id_i      (slv_id),
        .slv_gnt_o     (slv_gnt),
        .slv_r_valid_o (slv_r_valid),
        .slv_r_rdata_o (slv_r_rdata),
        .slv_r_opc_o   (slv_r_opc),
        .slv_r_id_o    (slv_r_id),
        .mst_req_o     (mst_req),
        .mst_add_o     (mst_add),
        .mst_wen_o     (mst_wen),
        .mst_wdata_o   (mst_wdata),
        .mst_be_o      (mst_be),
        .mst_id_o      (mst_id),
        .mst_gnt_i     (mst_gnt),
        .mst_r_valid_i (mst_r_valid),
        .mst_r_rdata_i (mst_r_rdata),
        .mst_r_opc_i   (mst_r_opc),
        .mst_r_id_i    (mst_r_id),
        .err_o         (err)
    );

    int checks   = 0;
    int failures = 0;

    logic [1:0]  exp_gnt_q [$];
    logic [1:0]  exp_rv_q  [$];
    logic [31:0] exp_rd_q  [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_rsp(input logic [1:0] owner, input logic [31:0] data);
        exp_rv_q.push_back(owner);
        exp_rd_q.push_back(data);
    endtask

    // Drive one cycle of stimulus just after the active edge.
    task automatic drive(input logic [1:0] req, input logic g, input logic rv,
                         input logic [31:0] rd);
        @(posedge clk);
        #1;
        slv_req     = req;
        mst_gnt     = g;
        mst_r_valid = rv;
        mst_r_rdata = rd;
        mst_r_id    = rd[IW-1:0];
        mst_r_opc   = rd[31];
    endtask

    // Monitor: every grant and response the DUT presents is matched in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (slv_gnt != 2'b00) begin
                if (exp_gnt_q.size() == 0) chk("gnt_unexpected", 32'(slv_gnt), 32'h0);
                else chk("gnt_order", 32'(slv_gnt), 32'(exp_gnt_q.pop_front()));
            end
            if (slv_r_valid != 2'b00) begin
                if (exp_rv_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'(slv_r_valid), 32'h0);
                end else begin
                    logic [31:0] d;
                    chk("rvalid_route", 32'(slv_r_valid), 32'(exp_rv_q.pop_front()));
                    d = exp_rd_q.pop_front();
                    chk("rdata", slv_r_rdata, d);
                    chk("rid", 32'(slv_r_id), 32'(d[IW-1:0]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq [4];
        seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        rst = 1'b1;
        slv_req = '0;
        slv_add[0] = ADD0;   slv_add[1] = ADD1;
        slv_wen[0] = 1'b0;   slv_wen[1] = 1'b1;
        slv_wdata[0] = 32'hAAAA_0000; slv_wdata[1] = 32'hBBBB_1111;
        slv_be[0] = 4'hF;    slv_be[1] = 4'h3;
        slv_id[0] = 5'd3;    slv_id[1] = 5'd17;
        mst_gnt = 1'b0; mst_r_valid = 1'b0; mst_r_rdata = '0; mst_r_opc = 1'b0; mst_r_id = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_gnt", 32'(slv_gnt), 32'h0);
        chk("reset_rvalid", 32'(slv_r_valid), 32'h0);
        chk("reset_mst_req", 32'(mst_req), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        chk("reset_mst_add", mst_add, 32'h0);

        // Single plug-1 read with one-cycle response.
        drive(2'b10, 1'b1, 1'b0, 32'h0);
        exp_gnt_q.push_back(2'b10);
        @(negedge clk);
        chk("t1_mst_add", mst_add, ADD1);
        chk("t1_mst_wen", 32'(mst_wen), 32'h1);
        chk("t1_mst_id", 32'(mst_id), 32'd17);
        drive(2'b00, 1'b0, 1'b1, 32'hCAFE_0001);
        push_rsp(2'b10, 32'hCAFE_0001);
        drive(2'b00, 1'b0, 1'b0, 32'h0);

        // Both plugs streaming, grant every cycle.
        for (int i = 0; i < 5; i++) begin
            drive((i < 4) ? 2'b11 : 2'b00, (i < 4), (i > 0), 32'hD000_0000 + 32'(i));
            if (i < 4) exp_gnt_q.push_back(seq[i]);
            if (i > 0) push_rsp(seq[i-1], 32'hD000_0000 + 32'(i));
        end
        drive(2'b00, 1'b0, 1'b0, 32'h0);

        // Event unit stalls for three cycles: selection locks on plug 0.
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            chk("t3_req_stall", 32'(mst_req), 32'h1);
            chk("t3_gnt_stall", 32'(slv_gnt), 32'h0);
            chk("t3_sel_plug0", mst_add, ADD0);
        end
        drive(2'b11, 1'b1, 1'b0, 32'h0); exp_gnt_q.push_back(2'b01);
        drive(2'b11, 1'b1, 1'b0, 32'h0); exp_gnt_q.push_back(2'b10);
        drive(2'b00, 1'b0, 1'b1, 32'h3300_0001); push_rsp(2'b01, 32'h3300_0001);
        drive(2'b00, 1'b0, 1'b1, 32'h3300_0002); push_rsp(2'b10, 32'h3300_0002);
        drive(2'b00, 1'b0, 1'b0, 32'h0);

        // Owner FIFO fills with responses withheld.
        drive(2'b11, 1'b1, 1'b0, 32'h0); exp_gnt_q.push_back(2'b01);
        drive(2'b11, 1'b1, 1'b0, 32'h0); exp_gnt_q.push_back(2'b10);
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t4_full_req", 32'(mst_req), 32'h0);
        chk("t4_full_gnt", 32'(slv_gnt), 32'h0);
        drive(2'b11, 1'b1, 1'b1, 32'h4400_0001); push_rsp(2'b01, 32'h4400_0001);
        @(negedge clk);
        chk("t4_full_pop_req", 32'(mst_req), 32'h0);
        chk("t4_full_pop_gnt", 32'(slv_gnt), 32'h0);
        drive(2'b11, 1'b1, 1'b0, 32'h0); exp_gnt_q.push_back(2'b01);
        @(negedge clk);
        chk("t4_resume_req", 32'(mst_req), 32'h1);
        drive(2'b00, 1'b0, 1'b1, 32'h4400_0002); push_rsp(2'b10, 32'h4400_0002);
        drive(2'b00, 1'b0, 1'b1, 32'h4400_0003); push_rsp(2'b01, 32'h4400_0003);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("t4_no_err", 32'(err), 32'h0);

        // Spurious response with nothing outstanding.
        drive(2'b00, 1'b0, 1'b1, 32'hBAD0_0005);
        @(negedge clk);
        chk("t5_spurious_rvalid", 32'(slv_r_valid), 32'h0);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("t5_err_set", 32'(err), 32'h1);
        repeat (3) drive(2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("t5_err_sticky", 32'(err), 32'h1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_err_cleared", 32'(err), 32'h0);

        // Reset with one transaction outstanding, then a stale response.
        drive(2'b01, 1'b1, 1'b0, 32'h0); exp_gnt_q.push_back(2'b01);
        @(posedge clk); #1;
        rst = 1'b1; slv_req = 2'b00; mst_gnt = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        drive(2'b00, 1'b0, 1'b1, 32'h5700_0006);
        @(negedge clk);
        chk("t6_stale_dropped", 32'(slv_r_valid), 32'h0);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("t6_err_set", 32'(err), 32'h1);
        drive(2'b11, 1'b1, 1'b0, 32'h0); exp_gnt_q.push_back(2'b01);
        drive(2'b00, 1'b0, 1'b1, 32'h6600_0007); push_rsp(2'b01, 32'h6600_0007);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);

        chk("gnt_queue_drained", 32'(exp_gnt_q.size()), 32'h0);
        chk("rsp_queue_drained", 32'(exp_rv_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
